event_led_flasher: RTL and testbench

Parametrised multi-channel event indicator for the board's tri-colour LEDs. Each channel watches one game counter, such as score or miss. When that counter changes, the channel lights its LED in a configured colour for a programmable number of slow ticks, either solid or blinking. An internal prescaler generates the ticks, and change detection runs at full clock rate, so no event is missed between ticks. The block sits between the game-state logic and the LED pins and replaces the fixed two-channel score/miss flasher.

---
 rtl/event_led_flasher_if.sv | 14 +
 rtl/event_led_flasher.sv | 82 ++++++++
 tb/tb_event_led_flasher.sv | 107 ++++++++++
 3 files changed

// File: rtl/event_led_flasher_if.sv
// Signal bundle between game-state logic (master) and the LED event flasher (slave).
interface event_led_flasher_if #(
    parameter int CH    = 2,
    parameter int VAL_W = 4
);
    logic [CH*VAL_W-1:0] val;
    logic [CH*3-1:0]     color_cfg;
    logic [CH-1:0]       mode;
    logic [CH*3-1:0]     led;
    logic [CH-1:0]       busy;

    modport master (output val, output color_cfg, output mode, input led, input busy);
    modport slave  (input val, input color_cfg, input mode, output led, output busy);
endinterface

// File: rtl/event_led_flasher.sv
// Multi-channel event indicator: any change of a watched value lights the
// channel's LED (solid or blinking) for HOLD_TICKS prescaler ticks.
module event_led_flasher #(
    parameter int CH         = 2,
    parameter int VAL_W      = 4,
    parameter int PRESCALE   = 50000,
    parameter int HOLD_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst,
    event_led_flasher_if.slave  io
);
    localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          tick;
    logic [CH-1:0][VAL_W-1:0]      shadow_q, shadow_d;
    logic [CH-1:0]                 primed_q, primed_d;
    logic [CH-1:0][HOLD_W-1:0]     hold_q, hold_d;
    logic [CH-1:0]                 phase_q, phase_d;
    logic [CH-1:0][2:0]            col_q, col_d;
    logic [CH*3-1:0]               led_q, led_d;

    always_comb begin
        tick  = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Change detection compares against the registered shadow at full rate;
    // a change in a tick cycle reloads and the tick is dropped for that channel.
    always_comb begin
        shadow_d = shadow_q;
        primed_d = primed_q;
        hold_d   = hold_q;
        phase_d  = phase_q;
        col_d    = col_q;
        led_d    = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (!primed_q[i]) begin
                shadow_d[i] = io.val[i*VAL_W +: VAL_W];
                primed_d[i] = 1'b1;
            end else if (io.val[i*VAL_W +: VAL_W] != shadow_q[i]) begin
                shadow_d[i] = io.val[i*VAL_W +: VAL_W];
                hold_d[i]   = HOLD_W'(HOLD_TICKS);
                phase_d[i]  = 1'b1;
                col_d[i]    = io.color_cfg[i*3 +: 3];
            end else if (tick && hold_q[i] != '0) begin
                hold_d[i]  = hold_q[i] - HOLD_W'(1);
                phase_d[i] = ~phase_q[i];
            end
            if (hold_d[i] != '0 && (!io.mode[i] || phase_d[i]))
                led_d[i*3 +: 3] = col_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            primed_q <= '0;
            hold_q   <= '0;
            phase_q  <= '0;
            col_q    <= '0;
            led_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            primed_q <= primed_d;
            hold_q   <= hold_d;
            phase_q  <= phase_d;
            col_q    <= col_d;
            led_q    <= led_d;
        end
    end

    always_comb begin
        io.led = led_q;
        for (int unsigned i = 0; i < CH; i++)
            io.busy[i] = (hold_q[i] != '0);
    end
endmodule

// File: tb/tb_event_led_flasher.sv
// Directed bench for event_led_flasher with CH=2, VAL_W=4, PRESCALE=4, HOLD_TICKS=3.
module tb_event_led_flasher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    event_led_flasher_if #(.CH(2), .VAL_W(4)) bus ();

    event_led_flasher #(
        .CH(2), .VAL_W(4), .PRESCALE(4), .HOLD_TICKS(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n edges; after each, check led and busy (cyc counts edges since reset release).
    task automatic run_expect(input int n, input logic [5:0] exp_led, input logic [1:0] exp_busy,
                              input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            check($sformatf("%s led e%0d", tag, cyc), {2'b00, bus.led}, {2'b00, exp_led});
            check($sformatf("%s busy e%0d", tag, cyc), {6'b0, bus.busy}, {6'b0, exp_busy});
        end
    endtask

    initial begin
        bus.val       = {4'd5, 4'd9};
        bus.color_cfg = {3'b000, 3'b011};
        bus.mode      = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset led", {2'b00, bus.led}, 8'h00);
        check("reset busy", {6'b0, bus.busy}, 8'h00);
        rst = 1'b0;
        cyc = 0;

        // 1: priming with steady values, never lit
        run_expect(50, 6'b000_000, 2'b00, "prime");

        // 2: ch0 9->10 at cyc 50; ticks fall on edges 52,56,60 -> lit edges 51..59
        bus.val[3:0] = 4'd10;
        run_expect(9, 6'b000_011, 2'b01, "solid");
        run_expect(3, 6'b000_000, 2'b00, "solid_end");

        // 3: ch1 blink; change at cyc 62 -> on e63, off e64..67, on e68..71, off e72
        bus.mode          = 2'b10;
        bus.color_cfg[5:3] = 3'b100;
        bus.val[7:4]      = 4'd6;
        run_expect(1, 6'b100_000, 2'b10, "blink_on1");
        run_expect(4, 6'b000_000, 2'b10, "blink_off");
        run_expect(4, 6'b100_000, 2'b10, "blink_on2");
        run_expect(2, 6'b000_000, 2'b00, "blink_end");

        // 4: ch0 change at cyc 73, colour edit mid-flash ignored, retrigger lands on tick e80
        bus.mode = 2'b00;
        bus.val[3:0] = 4'd11;
        run_expect(3, 6'b000_011, 2'b01, "retrig_a");
        bus.color_cfg[2:0] = 3'b101;
        run_expect(3, 6'b000_011, 2'b01, "col_latched");
        bus.val[3:0] = 4'd12;
        run_expect(12, 6'b000_101, 2'b01, "retrig_tick");
        run_expect(2, 6'b000_000, 2'b00, "retrig_end");

        // 5: both channels change at cyc 93; ticks e96,100,104 -> lit e94..103
        bus.color_cfg = {3'b001, 3'b010};
        bus.val       = {4'd7, 4'd13};
        run_expect(10, 6'b001_010, 2'b11, "simul");
        run_expect(2, 6'b000_000, 2'b00, "simul_end");

        // 6: reset mid-flash blanks at once; release re-primes without flashing
        bus.val[3:0] = 4'd14;
        run_expect(2, 6'b000_010, 2'b01, "pre_rst");
        rst = 1'b1;
        #1;
        check("rst_async led", {2'b00, bus.led}, 8'h00);
        check("rst_async busy", {6'b0, bus.busy}, 8'h00);
        bus.val[3:0] = 4'd15;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        run_expect(6, 6'b000_000, 2'b00, "reprime");
        // wrap 15->0 at cyc 6; ticks e8,12,16 -> lit e7..15
        bus.color_cfg[2:0] = 3'b111;
        bus.val[3:0] = 4'd0;
        run_expect(9, 6'b000_111, 2'b01, "post_rst");
        run_expect(2, 6'b000_000, 2'b00, "post_rst_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
